// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor. The pipe handles one GROUP-bit look-ahead block per stage.
// Operands and partial sums move through it skewed, under a valid/ready handshake with a global stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / GROUP;

    // Returns {carry into top bit, carry out, group sum}.
    // Each carry is a flat sum of generate/propagate products, so no carry ripples inside the group.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] ga,
        input logic [GROUP-1:0] gb,
        input logic             c0
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             advance_s;
    logic [GROUP+1:0] grp_s;
    logic [GROUP+1:0] last_s;

    logic             vld_q  [0:N-1];
    logic             vld_d  [0:N-1];
    logic [WIDTH-1:0] opa_q  [0:N-1];
    logic [WIDTH-1:0] opa_d  [0:N-1];
    logic [WIDTH-1:0] opb_q  [0:N-1];
    logic [WIDTH-1:0] opb_d  [0:N-1];
    logic [WIDTH-1:0] psum_q [0:N-1];
    logic [WIDTH-1:0] psum_d [0:N-1];
    logic             cry_q  [0:N-1];
    logic             cry_d  [0:N-1];

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Next-state of every stage: entry capture, one look-ahead group per stage, final group into the output.
    always_comb begin
        grp_s     = '0;
        vld_d[0]  = in_valid;
        opa_d[0]  = a;
        opb_d[0]  = sub ? ~b : b;
        cry_d[0]  = sub ? 1'b1 : cin;
        psum_d[0] = '0;
        for (int k = 1; k < N; k++) begin
            grp_s     = cla_group(opa_q[k-1][(k-1)*GROUP +: GROUP],
                                  opb_q[k-1][(k-1)*GROUP +: GROUP], cry_q[k-1]);
            vld_d[k]  = vld_q[k-1];
            opa_d[k]  = opa_q[k-1];
            opb_d[k]  = opb_q[k-1];
            cry_d[k]  = grp_s[GROUP];
            psum_d[k] = psum_q[k-1];
            psum_d[k][(k-1)*GROUP +: GROUP] = grp_s[GROUP-1:0];
        end
        last_s = cla_group(opa_q[N-1][(N-1)*GROUP +: GROUP],
                           opb_q[N-1][(N-1)*GROUP +: GROUP], cry_q[N-1]);
        out_valid_d = vld_q[N-1];
        // Empty slots present zeros so stale stage data never reaches the outputs.
        if (vld_q[N-1]) begin
            sum_d = psum_q[N-1];
            sum_d[(N-1)*GROUP +: GROUP] = last_s[GROUP-1:0];
            cout_d = last_s[GROUP];
            ovf_d  = last_s[GROUP+1] ^ last_s[GROUP];
        end else begin
            sum_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    // Valid bits and output registers: cleared by reset, frozen while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < N; k++) begin
                vld_q[k] <= vld_d[k];
            end
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    // Stage data registers: no reset needed, since they only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (advance_s) begin
            for (int k = 0; k < N; k++) begin
                opa_q[k]  <= opa_d[k];
                opb_q[k]  <= opb_d[k];
                psum_q[k] <= psum_d[k];
                cry_q[k]  <= cry_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (WIDTH=16, GROUP=4): the driver queues expected results,
// and an independent monitor pops and compares them on every output transfer.
module tb_pipelined_cla_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_res = 18'd0;
    int          idle_c = 0;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Behavioural reference: plain wide addition, with overflow taken from the operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [15:0] bb;
        logic [16:0] r;
        logic        ci;
        bb = ms ? ~mb : mb;
        ci = ms ? 1'b1 : mc;
        r  = {1'b0, ma} + {1'b0, bb} + {16'd0, ci};
        return {r[15:0], r[16], (ma[15] == bb[15]) && (r[15] != ma[15])};
    endfunction

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo, input bit lat);
        int   waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
        #1;
        while (!in_ready && waitc < 500) begin
            waitc++;
            @(negedge clk);
            #1;
        end
        if (in_ready) begin
            e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1; e.lat = lat;
            exp_q.push_back(e);
        end else begin
            check("in_ready timeout", {31'd0, in_ready}, 32'd1);
        end
    endtask

    task automatic rand_send();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;
        logic [17:0] m;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        m  = model(ra, rb, rc, rs);
        send(ra, rb, rc, rs, m[17:2], m[1], m[0], 1'b0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain queue empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: samples away from the active edge and scores every output transfer and stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall hold valid", {31'd0, out_valid}, 32'd1);
                    check("stall hold data", {14'd0, sum, cout, ovf}, {14'd0, prev_res});
                end
                if (out_valid === 1'b1 && out_ready === 1'b0)
                    check("in_ready while stalled", {31'd0, in_ready}, 32'd0);
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    idle_c = 0;
                    if (exp_q.size() == 0) begin
                        check("output with empty queue", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result {sum,cout,ovf}", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.o});
                        if (e.lat) check("latency", cyc - e.acc, 32'd4);
                    end
                end else if (exp_q.size() != 0) begin
                    idle_c++;
                    if (idle_c > 300) begin
                        check("output timeout", idle_c, 32'd0);
                        idle_c = 0;
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
                prev_res   = {sum, cout, ovf};
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset sum", {16'd0, sum}, 32'd0);
        check("reset cout/ovf", {30'd0, cout, ovf}, 32'd0);
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Directed vectors with hand-computed results.
        send(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        idle();
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
        idle();
        drain();

        // Eight back-to-back mixed operations with a three-cycle downstream stall mid-stream.
        fork
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        repeat (8) rand_send();
        idle();
        drain();

        // Reset with three operations in flight: none may emerge, and the next one takes 4 cycles.
        repeat (3) rand_send();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-flight reset out_valid", {31'd0, out_valid}, 32'd0);
        check("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
        send(16'hA5A5, 16'h0F0F, 1'b0, 1'b1, 16'h9696, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        repeat (10) @(negedge clk);

        // Long random run with random gaps on both sides of the pipe.
        rnd_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            rand_send();
        end
        rnd_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
